// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake to instruction
// memory, honours decode freeze/redirect (with delay slot) and buffers one instruction.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Alt_PC_IN,
    input  logic        Request_Alt_PC_IN,
    input  logic        FREEZE_IN,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic [31:0] IMem_Data,
    input  logic        IMem_Ack,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT,
    output logic [31:0] Fetch_Count_OUT
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_buf_instr, w_buf_instr_next;
    logic [31:0] r_buf_pc, w_buf_pc_next;
    logic        r_redir_valid, w_redir_valid_next;
    logic [31:0] r_redir_pc, w_redir_pc_next;
    logic [31:0] r_instr, w_instr_next;
    logic [31:0] r_instr_pc, w_instr_pc_next;
    logic [31:0] r_instr_pc4, w_instr_pc4_next;
    logic [31:0] r_count, w_count_next;
    logic        w_ack;
    logic [31:0] w_pc_plus4;

    always_comb begin
        // An ack is only meaningful while a request is outstanding (RUN).
        w_ack              = IMem_Ack & (r_state == ST_RUN);
        w_pc_plus4         = r_pc + 32'd4;
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_buf_instr_next   = r_buf_instr;
        w_buf_pc_next      = r_buf_pc;
        w_redir_valid_next = r_redir_valid;
        w_redir_pc_next    = r_redir_pc;
        w_instr_next       = r_instr;
        w_instr_pc_next    = r_instr_pc;
        w_instr_pc4_next   = r_instr_pc4;
        w_count_next       = r_count;

        // The fetch completing now is the delay slot; the redirect steers the one after it.
        if (w_ack) begin
            w_redir_valid_next = 1'b0;
            if (Request_Alt_PC_IN)
                w_pc_next = Alt_PC_IN;
            else if (r_redir_valid)
                w_pc_next = r_redir_pc;
            else
                w_pc_next = w_pc_plus4;
        end else if (Request_Alt_PC_IN && !FREEZE_IN) begin
            w_redir_valid_next = 1'b1;
            w_redir_pc_next    = Alt_PC_IN;
        end

        case (r_state)
            ST_RUN: begin
                if (!FREEZE_IN) begin
                    if (w_ack) begin
                        w_instr_next     = IMem_Data;
                        w_instr_pc_next  = r_pc;
                        w_instr_pc4_next = w_pc_plus4;
                        w_count_next     = r_count + 32'd1;
                    end else begin
                        w_instr_next = 32'd0;
                    end
                end else if (w_ack) begin
                    w_buf_instr_next = IMem_Data;
                    w_buf_pc_next    = r_pc;
                    w_state_next     = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!FREEZE_IN) begin
                    w_instr_next     = r_buf_instr;
                    w_instr_pc_next  = r_buf_pc;
                    w_instr_pc4_next = r_buf_pc + 32'd4;
                    w_count_next     = r_count + 32'd1;
                    w_state_next     = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_buf_instr   <= 32'd0;
            r_buf_pc      <= 32'd0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= 32'd0;
            r_instr       <= 32'd0;
            r_instr_pc    <= 32'd0;
            r_instr_pc4   <= 32'd0;
            r_count       <= 32'd0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_buf_instr   <= w_buf_instr_next;
            r_buf_pc      <= w_buf_pc_next;
            r_redir_valid <= w_redir_valid_next;
            r_redir_pc    <= w_redir_pc_next;
            r_instr       <= w_instr_next;
            r_instr_pc    <= w_instr_pc_next;
            r_instr_pc4   <= w_instr_pc4_next;
            r_count       <= w_count_next;
        end
    end

    assign IMem_Req           = RESET & (r_state == ST_RUN);
    assign IMem_Addr          = r_pc;
    assign Instr1_OUT         = r_instr;
    assign Instr_PC_OUT       = r_instr_pc;
    assign Instr_PC_Plus4_OUT = r_instr_pc4;
    assign Fetch_Count_OUT    = r_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, reset-mid-request sequence,
// then randomized traffic checked against a queue-based reference model.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h00400000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] Alt_PC_IN = 32'd0;
    logic        Request_Alt_PC_IN = 1'b0;
    logic        FREEZE_IN = 1'b0;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic [31:0] IMem_Data = 32'd0;
    logic        IMem_Ack = 1'b0;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;
    logic [31:0] Fetch_Count_OUT;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .Alt_PC_IN         (Alt_PC_IN),
        .Request_Alt_PC_IN (Request_Alt_PC_IN),
        .FREEZE_IN         (FREEZE_IN),
        .IMem_Req          (IMem_Req),
        .IMem_Addr         (IMem_Addr),
        .IMem_Data         (IMem_Data),
        .IMem_Ack          (IMem_Ack),
        .Instr1_OUT        (Instr1_OUT),
        .Instr_PC_OUT      (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
        .Fetch_Count_OUT   (Fetch_Count_OUT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        frz;
        logic        rq;
        logic [31:0] alt;
        logic        ack;
        logic [31:0] data;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic frz, input logic rq, input logic [31:0] alt,
                                input logic ack, input logic [31:0] data,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic [31:0] ec, input logic er, input logic [31:0] ea);
        vec_t v;
        v.frz = frz; v.rq = rq; v.alt = alt; v.ack = ack; v.data = data;
        v.e_instr = ei; v.e_pc = ep; v.e_cnt = ec; v.e_req = er; v.e_addr = ea;
        return v;
    endfunction

    // Reference model: PC, one-deep buffer and pending redirect kept as queues.
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
    logic [31:0] m_buf_i[$];
    logic [31:0] m_buf_p[$];
    logic [31:0] m_redir[$];

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_cnt = 0;
        m_buf_i.delete(); m_buf_p.delete(); m_redir.delete();
    endtask

    task automatic model_deliver(input logic [31:0] d, input logic [31:0] p);
        m_instr = d; m_ipc = p; m_ipc4 = p + 32'd4; m_cnt = m_cnt + 32'd1;
    endtask

    task automatic model_edge(input logic frz, input logic rq, input logic [31:0] alt,
                              input logic ack, input logic [31:0] data);
        logic        full;
        logic        a;
        logic [31:0] old_pc;
        full   = (m_buf_i.size() != 0);
        a      = ack && !full;
        old_pc = m_pc;
        if (a) begin
            if (rq) begin
                m_pc = alt;
                m_redir.delete();
            end else if (m_redir.size() != 0) begin
                m_pc = m_redir.pop_front();
            end else begin
                m_pc = old_pc + 32'd4;
            end
        end else if (rq && !frz) begin
            m_redir.delete();
            m_redir.push_back(alt);
        end
        if (!full) begin
            if (!frz) begin
                if (a) model_deliver(data, old_pc);
                else   m_instr = 32'd0;
            end else if (a) begin
                m_buf_i.push_back(data);
                m_buf_p.push_back(old_pc);
            end
        end else if (!frz) begin
            model_deliver(m_buf_i.pop_front(), m_buf_p.pop_front());
        end
    endtask

    task automatic model_compare(input int cyc);
        chk($sformatf("rnd%0d_instr", cyc), Instr1_OUT, m_instr);
        chk($sformatf("rnd%0d_pc", cyc), Instr_PC_OUT, m_ipc);
        chk($sformatf("rnd%0d_pc4", cyc), Instr_PC_Plus4_OUT, m_ipc4);
        chk($sformatf("rnd%0d_cnt", cyc), Fetch_Count_OUT, m_cnt);
        chk($sformatf("rnd%0d_req", cyc), {31'd0, IMem_Req}, {31'd0, m_buf_i.size() == 0});
        chk($sformatf("rnd%0d_addr", cyc), IMem_Addr, m_pc);
    endtask

    task automatic drive(input logic frz, input logic rq, input logic [31:0] alt,
                         input logic ack, input logic [31:0] data);
        FREEZE_IN = frz; Request_Alt_PC_IN = rq; Alt_PC_IN = alt; IMem_Ack = ack; IMem_Data = data;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        drive(0, 0, 0, 0, 0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 0, 1, 32'h00400000, 32'h00400000, 32'h00400000, 1, 1, 32'h00400004);
        tbl[1]  = mk(0, 0, 0, 1, 32'h00400004, 32'h00400004, 32'h00400004, 2, 1, 32'h00400008);
        tbl[2]  = mk(0, 0, 0, 1, 32'h00400008, 32'h00400008, 32'h00400008, 3, 1, 32'h0040000C);
        tbl[3]  = mk(0, 0, 0, 1, 32'h0040000C, 32'h0040000C, 32'h0040000C, 4, 1, 32'h00400010);
        tbl[4]  = mk(0, 0, 0, 1, 32'h00400010, 32'h00400010, 32'h00400010, 5, 1, 32'h00400014);
        tbl[5]  = mk(0, 1, 32'h00400100, 1, 32'h00400014, 32'h00400014, 32'h00400014, 6, 1, 32'h00400100);
        tbl[6]  = mk(0, 0, 0, 1, 32'h00400100, 32'h00400100, 32'h00400100, 7, 1, 32'h00400104);
        tbl[7]  = mk(0, 0, 0, 0, 0, 32'h0, 32'h00400100, 7, 1, 32'h00400104);
        tbl[8]  = mk(0, 1, 32'h00400200, 0, 0, 32'h0, 32'h00400100, 7, 1, 32'h00400104);
        tbl[9]  = mk(0, 0, 0, 0, 0, 32'h0, 32'h00400100, 7, 1, 32'h00400104);
        tbl[10] = mk(0, 0, 0, 1, 32'h00400104, 32'h00400104, 32'h00400104, 8, 1, 32'h00400200);
        tbl[11] = mk(1, 0, 0, 1, 32'h00400200, 32'h00400104, 32'h00400104, 8, 0, 32'h00400204);
        tbl[12] = mk(1, 0, 0, 0, 0, 32'h00400104, 32'h00400104, 8, 0, 32'h00400204);
        tbl[13] = mk(1, 0, 0, 0, 0, 32'h00400104, 32'h00400104, 8, 0, 32'h00400204);
        tbl[14] = mk(1, 0, 0, 0, 0, 32'h00400104, 32'h00400104, 8, 0, 32'h00400204);
        tbl[15] = mk(0, 0, 0, 0, 0, 32'h00400200, 32'h00400200, 9, 1, 32'h00400204);
        tbl[16] = mk(0, 0, 0, 1, 32'h00400204, 32'h00400204, 32'h00400204, 10, 1, 32'h00400208);
        tbl[17] = mk(1, 1, 32'h00400300, 0, 0, 32'h00400204, 32'h00400204, 10, 1, 32'h00400208);
        tbl[18] = mk(1, 1, 32'h00400300, 1, 32'h00400208, 32'h00400204, 32'h00400204, 10, 0, 32'h00400300);
        tbl[19] = mk(1, 1, 32'h00400300, 0, 0, 32'h00400204, 32'h00400204, 10, 0, 32'h00400300);
        tbl[20] = mk(0, 0, 0, 0, 0, 32'h00400208, 32'h00400208, 11, 1, 32'h00400300);
        tbl[21] = mk(0, 0, 0, 1, 32'h00400300, 32'h00400300, 32'h00400300, 12, 1, 32'h00400304);
        tbl[22] = mk(0, 1, 32'hFFFFFFFC, 1, 32'h00400304, 32'h00400304, 32'h00400304, 13, 1, 32'hFFFFFFFC);
        tbl[23] = mk(0, 0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 14, 1, 32'h00000000);

        // Reset values
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_instr", Instr1_OUT, 32'd0);
        chk("rst_pc", Instr_PC_OUT, 32'd0);
        chk("rst_pc4", Instr_PC_Plus4_OUT, 32'd0);
        chk("rst_cnt", Fetch_Count_OUT, 32'd0);
        chk("rst_req", {31'd0, IMem_Req}, 32'd0);
        RESET = 1'b1;
        #1;
        chk("first_req", {31'd0, IMem_Req}, 32'd1);
        chk("first_addr", IMem_Addr, RESET_PC);

        // Directed vector table: sequential fetch, branch+delay slot, slow ack, freezes, wrap
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].frz, tbl[i].rq, tbl[i].alt, tbl[i].ack, tbl[i].data);
            @(posedge CLK);
            @(negedge CLK);
            #1;
            chk($sformatf("vec%0d_instr", i), Instr1_OUT, tbl[i].e_instr);
            chk($sformatf("vec%0d_pc", i), Instr_PC_OUT, tbl[i].e_pc);
            chk($sformatf("vec%0d_pc4", i), Instr_PC_Plus4_OUT, tbl[i].e_pc + 32'd4);
            chk($sformatf("vec%0d_cnt", i), Fetch_Count_OUT, tbl[i].e_cnt);
            chk($sformatf("vec%0d_req", i), {31'd0, IMem_Req}, {31'd0, tbl[i].e_req});
            chk($sformatf("vec%0d_addr", i), IMem_Addr, tbl[i].e_addr);
            $display("vec %0d: instr=%h pc=%h cnt=%0d req=%0d addr=%h", i,
                     Instr1_OUT, Instr_PC_OUT, Fetch_Count_OUT, IMem_Req, IMem_Addr);
        end

        // Reset pulsed while the request to 0x00400040 is outstanding
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(0, 0, 0, 1, RESET_PC + 32'(k * 4));
            @(negedge CLK);
        end
        drive(0, 0, 0, 0, 0);
        #1;
        chk("midreq_addr", IMem_Addr, 32'h00400040);
        chk("midreq_cnt", Fetch_Count_OUT, 32'd16);
        #1;
        RESET = 1'b0;
        #1;
        chk("async_rst_instr", Instr1_OUT, 32'd0);
        chk("async_rst_pc", Instr_PC_OUT, 32'd0);
        chk("async_rst_cnt", Fetch_Count_OUT, 32'd0);
        chk("async_rst_req", {31'd0, IMem_Req}, 32'd0);
        drive(0, 0, 0, 1, 32'hDEADBEEF);
        @(negedge CLK);
        drive(0, 0, 0, 0, 0);
        RESET = 1'b1;
        #1;
        chk("rerel_addr", IMem_Addr, RESET_PC);
        chk("rerel_req", {31'd0, IMem_Req}, 32'd1);
        chk("rerel_instr", Instr1_OUT, 32'd0);
        drive(0, 0, 0, 1, RESET_PC);
        @(negedge CLK);
        #1;
        chk("rerel_first_pc", Instr_PC_OUT, RESET_PC);
        chk("rerel_first_cnt", Fetch_Count_OUT, 32'd1);
        $display("reset-mid-request: addr=%h pc=%h cnt=%0d", IMem_Addr, Instr_PC_OUT, Fetch_Count_OUT);

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        begin
            int          wait_cnt;
            int          lat;
            logic        frz, rq, ack, mreq;
            logic [31:0] alt, data;
            wait_cnt = 0;
            lat = $urandom_range(0, 3);
            for (int c = 0; c < 3000; c++) begin
                #1;
                model_compare(c);
                frz  = ($urandom_range(0, 3) == 0);
                rq   = ($urandom_range(0, 6) == 0);
                alt  = RESET_PC + (32'($urandom_range(0, 255)) << 2);
                mreq = (m_buf_i.size() == 0);
                if (mreq) begin
                    if (wait_cnt >= lat) begin
                        ack = 1'b1;
                        wait_cnt = 0;
                        lat = $urandom_range(0, 3);
                    end else begin
                        ack = 1'b0;
                        wait_cnt++;
                    end
                    data = ack ? (m_pc ^ 32'h5A5A0000) : $urandom;
                end else begin
                    ack  = ($urandom_range(0, 3) == 0);
                    data = $urandom;
                end
                drive(frz, rq, alt, ack, data);
                model_edge(frz, rq, alt, ack, data);
                @(negedge CLK);
            end
            #1;
            model_compare(3000);
            $display("random: delivered=%0d pc=%h", m_cnt, m_pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
